// File: rtl/pipe_pkg.sv
// pipe_pkg: shared entry type and default widths for the skid pipeline stage
package pipe_pkg;
  localparam int PC_W_DEF = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int CNT_W_DEF = 16;
  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic [INSTR_W_DEF-1:0] instr;
  } pipe_entry_t;
endpackage

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid buffer with registered ready, flush and stall counting
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic out_valid,
  input  logic out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  pipe_entry_t m, s, in_e;
  logic m_valid, s_valid, rdy;
  logic in_xfer, out_xfer;
  assign in_e = '{pc: PC_W_DEF'(in_pc), instr: INSTR_W_DEF'(in_instr)};
  assign in_xfer = in_valid && rdy;
  assign out_xfer = m_valid && out_ready;
  assign in_ready = rdy;
  assign out_valid = m_valid;
  assign out_pc = PC_W'(m.pc);
  assign out_instr = INSTR_W'(m.instr);
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m <= '0;
      s <= '0;
      rdy <= 1'b1;
    end else if (!m_valid || out_xfer) begin
      // M refills from S first; S can only be valid here when M is draining
      m_valid <= s_valid || in_xfer;
      m <= s_valid ? s : in_xfer ? in_e : '0;
      s_valid <= 1'b0;
      s <= '0;
      rdy <= 1'b1;
    end else if (in_xfer) begin
      s_valid <= 1'b1;
      s <= in_e;
      rdy <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (m_valid && !out_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random scoreboard checks of the skid pipeline stage
module tb_pipe_stage_skid;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  logic [1:0] occupancy;
  logic [15:0] stall_cnt;
  logic sat_in_ready, sat_out_valid;
  logic [31:0] sat_out_pc, sat_out_instr;
  logic [1:0] sat_occupancy;
  logic [1:0] sat_stall_cnt;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [15:0] stall_before;

  always #5 clk = ~clk;

  pipe_stage_skid u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_pc(sat_out_pc), .out_instr(sat_out_instr),
    .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc = pc;
    in_instr = $urandom;
    step();
    in_valid = 1'b0;
  endtask

  // Transfers are decided from values stable mid-cycle, ahead of the edge that commits them
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_out", {out_pc, out_instr}, 64'hx);
        else chk("sb_order", {out_pc, out_instr}, sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back({in_pc, in_instr});
    end
    if (!rst && !out_valid) chk("empty_payload", {out_pc, out_instr}, 64'h0);
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_sat_stall", sat_stall_cnt, 0);

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc = 32'(i * 4);
      in_instr = 32'hC0DE_0000 + 32'(i);
      step();
      chk("stream_pc", out_pc, 64'(i * 4));
      chk("stream_instr", out_instr, 64'(32'hC0DE_0000 + 32'(i)));
      chk("stream_occ", occupancy, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_occ", occupancy, 0);

    out_ready = 1'b0;
    push(32'h10);
    chk("bp_occ1", occupancy, 1);
    push(32'h14);
    chk("bp_occ2", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_pc", out_pc, 32'h10);
    out_ready = 1'b1;
    step();
    chk("bp_second_pc", out_pc, 32'h14);
    chk("bp_in_ready_back", in_ready, 1);
    step();
    chk("bp_drained", out_valid, 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    push(32'h30);
    for (int i = 0; i < 5; i++) step();
    chk("stall_5", stall_cnt, 5);
    step();
    chk("stall_6", stall_cnt, 6);
    chk("stall_sat", sat_stall_cnt, 3);
    out_ready = 1'b1;
    step();
    chk("stall_hold", stall_cnt, 6);

    out_ready = 1'b0;
    push(32'h40);
    push(32'h44);
    chk("fl_occ2", occupancy, 2);
    stall_before = stall_cnt;
    flush = 1'b1;
    in_valid = 1'b1;
    in_pc = 32'h20;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ", occupancy, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_pc", out_pc, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_stall_kept", stall_cnt, stall_before + 16'd1);
    out_ready = 1'b1;
    step();
    step();
    chk("fl_no_emit", out_valid, 0);

    out_ready = 1'b0;
    push(32'h50);
    push(32'h54);
    chk("rm_occ2", occupancy, 2);
    rst = 1'b1;
    in_valid = 1'b1;
    in_pc = 32'h58;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rm_occ", occupancy, 0);
    chk("rm_in_ready", in_ready, 1);
    chk("rm_stall", stall_cnt, 0);
    chk("rm_out_valid", out_valid, 0);
    out_ready = 1'b1;
    step();
    step();
    chk("rm_no_emit", out_valid, 0);

    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 40) == 0;
      in_pc = $urandom;
      in_instr = $urandom;
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rand_sb_empty", sb.size(), 0);
    chk("rand_occ", occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
